// File: rtl/adc_sample_decimator.sv
// Block-average decimator: offset-binary 12-bit ADC words in, 16-bit two's-complement samples out.
// Optional DC-blocking stage compiled only when ADC_SAMPLE_DECIMATOR_DC_BLOCK_EN is defined.
module adc_sample_decimator #(
  parameter int unsigned DECIM_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [11:0] in_data,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  output logic        overrun
);
  localparam int unsigned ACC_W = 12 + DECIM_LOG2;
  localparam logic [DECIM_LOG2-1:0] CNT_LAST = '1;
  localparam logic [DECIM_LOG2-1:0] CNT_ONE  = DECIM_LOG2'(1);

  typedef enum logic {PRIME, RUN} state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [DECIM_LOG2-1:0]   r_cnt;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [11:0]      w_sample;
  logic signed [ACC_W-1:0] w_sum;
  logic [11:0]             w_avg;
  logic                    w_last;
  logic                    w_done;
  logic [15:0]             w_x;
  logic [15:0]             w_result;
  logic                    r_valid;
  logic [15:0]             r_data;
  logic                    r_overrun;

  assign w_sample = {~in_data[11], in_data[10:0]};
  assign w_sum    = r_acc + {{DECIM_LOG2{w_sample[11]}}, w_sample};
  // Top 12 bits of the sum are exactly the arithmetic shift right by DECIM_LOG2.
  assign w_avg    = w_sum[ACC_W-1 -: 12];
  assign w_x      = {w_avg, 4'b0};
  assign w_last   = in_valid && (r_cnt == CNT_LAST);
  assign w_done   = w_last && (r_state == RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= PRIME;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (r_state == PRIME && w_last) w_state_next = RUN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (in_valid) begin
      r_cnt <= r_cnt + CNT_ONE;
      if (r_state == RUN) r_acc <= w_last ? '0 : w_sum;
    end
  end

`ifdef ADC_SAMPLE_DECIMATOR_DC_BLOCK_EN
  logic signed [23:0] r_dc;
  logic signed [16:0] w_y;
  logic signed [16:0] w_dc_step;

  assign w_y = {w_x[15], w_x} - {r_dc[23], r_dc[23:8]};

  always_comb begin
    w_result = w_y[15:0];
    if (w_y[16] != w_y[15]) w_result = w_y[16] ? 16'h8000 : 16'h7FFF;
  end

  // ({x,8'b0} - dc) >>> 8 == x - ceil(dc/256) == (x - dc[23:8]) - |dc[7:0]
  assign w_dc_step = w_y - {16'b0, |r_dc[7:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       r_dc <= '0;
    else if (w_done) r_dc <= r_dc + {{7{w_dc_step[16]}}, w_dc_step};
  end
`else
  assign w_result = w_x;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_done && r_valid && !out_ready;
      if (w_done && !(r_valid && !out_ready)) begin
        r_valid <= 1'b1;
        r_data  <= w_result;
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign overrun   = r_overrun;
endmodule

// File: tb/tb_adc_sample_decimator.sv
// Self-checking bench for adc_sample_decimator (DECIM_LOG2=4) against a behavioural block-average model.
module tb_adc_sample_decimator;
  localparam int unsigned L = 4;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [11:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] out_data;
  logic        overrun;

  int errors = 0;
  int checks = 0;

  bit          m_valid;
  bit          m_ovr;
  logic [15:0] m_data;
  int          m_primed;
  int          m_blk[$];
  longint      m_dc;

  adc_sample_decimator #(.DECIM_LOG2(L)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_valid = 0; m_ovr = 0; m_data = '0; m_primed = 0; m_blk.delete(); m_dc = 0;
  endfunction

  function automatic void model_step(input bit v, input logic [11:0] d, input bit rdy);
    bit done;
    logic [15:0] res;
    int sum;
    longint x, y;
    done = 0; res = '0; sum = 0;
    if (v) begin
      if (m_primed < N) m_primed++;
      else begin
        m_blk.push_back(int'(d) - 2048);
        if (m_blk.size() == N) begin
          foreach (m_blk[i]) sum += m_blk[i];
          res = 16'(((sum >>> L) & 'hFFF) << 4);
`ifdef ADC_SAMPLE_DECIMATOR_DC_BLOCK_EN
          x = longint'($signed(res));
          y = x - (m_dc >>> 8);
          if (y > 32767) y = 32767;
          if (y < -32768) y = -32768;
          m_dc = m_dc + ((x * 256 - m_dc) >>> 8);
          res = 16'(y);
`else
          x = 0; y = 0;
`endif
          m_blk.delete();
          done = 1;
        end
      end
    end
    m_ovr = done && m_valid && !rdy;
    if (done && !(m_valid && !rdy)) begin
      m_valid = 1; m_data = res;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
  endfunction

  task automatic cyc(input bit v, input logic [11:0] d, input bit rdy);
    in_valid = v; in_data = d; out_ready = rdy;
    model_step(v, d, rdy);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic do_reset();
    reset = 1; in_valid = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    model_reset();
  endtask

  task automatic prime();
    repeat (N) cyc(1, 12'($urandom), 1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL rst_data: got %h want 0000", out_data); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_ovr: got %b want 0", overrun); end
    prime();
    repeat (N) cyc(1, 12'($urandom), 0);
    repeat (5) cyc(1, 12'($urandom), 0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_valid: got %b want 1", out_valid); end
    #2 reset = 1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_rst_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL async_rst_data: got %h want 0000", out_data); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL async_rst_ovr: got %b want 0", overrun); end
    @(posedge clk); #1 reset = 0;
    model_reset();
    for (int i = 0; i < N; i++) begin
      cyc(1, 12'($urandom), 1);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reprime_%0d: got valid %b want 0", i, out_valid); end
    end
    repeat (N) cyc(1, 12'($urandom), 0);
    checks++; if (out_valid !== 1'b1 || out_data !== m_data) begin
      errors++; $display("FAIL post_rst_block: got %b/%h want 1/%h", out_valid, out_data, m_data);
    end
  endtask

  task automatic test_averaging();
    do_reset();
    prime();
    for (int i = 0; i < N; i++) begin
      cyc(1, 12'hC00, 0);
      cyc(0, 12'($urandom), 0);
      if (i == N - 2) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL avg_early: got valid %b want 0", out_valid); end
      end
    end
    do_reset();
    prime();
    repeat (N - 1) cyc(1, 12'hC00, 0);
    cyc(1, 12'hC00, 0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL avg_latency: got valid %b want 1", out_valid); end
    checks++; if (out_data !== m_data) begin errors++; $display("FAIL avg_c00_model: got %h want %h", out_data, m_data); end
`ifndef ADC_SAMPLE_DECIMATOR_DC_BLOCK_EN
    checks++; if (out_data !== 16'h4000) begin errors++; $display("FAIL avg_c00: got %h want 4000", out_data); end
`endif
    cyc(0, 12'h0, 1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL avg_consume: got valid %b want 0", out_valid); end
    repeat (N) cyc(1, 12'h000, 1);
    checks++; if (out_valid !== 1'b1 || out_data !== m_data) begin
      errors++; $display("FAIL avg_000_model: got %b/%h want 1/%h", out_valid, out_data, m_data);
    end
`ifndef ADC_SAMPLE_DECIMATOR_DC_BLOCK_EN
    checks++; if (out_data !== 16'h8000) begin errors++; $display("FAIL avg_000: got %h want 8000", out_data); end
`endif
  endtask

  task automatic test_rounding();
    cyc(0, 12'h0, 1);
    repeat (8) cyc(1, 12'hFFF, 0);
    repeat (8) cyc(1, 12'h000, 0);
    checks++; if (out_valid !== 1'b1 || out_data !== m_data) begin
      errors++; $display("FAIL round_model: got %b/%h want 1/%h", out_valid, out_data, m_data);
    end
`ifndef ADC_SAMPLE_DECIMATOR_DC_BLOCK_EN
    checks++; if (out_data !== 16'hFFF0) begin errors++; $display("FAIL round_neg: got %h want FFF0", out_data); end
`endif
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_a;
    cyc(0, 12'h0, 1);
    repeat (N) cyc(1, 12'($urandom), 0);
    exp_a = m_data;
    checks++; if (out_valid !== 1'b1 || out_data !== exp_a) begin
      errors++; $display("FAIL bp_first: got %b/%h want 1/%h", out_valid, out_data, exp_a);
    end
    repeat (N) cyc(1, 12'($urandom), 0);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL bp_ovr_pulse: got %b want 1", overrun); end
    checks++; if (out_data !== exp_a || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_retain: got %b/%h want 1/%h", out_valid, out_data, exp_a);
    end
    cyc(0, 12'h0, 0);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL bp_ovr_single: got %b want 0", overrun); end
    cyc(0, 12'h0, 1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got valid %b want 0", out_valid); end
    repeat (N) cyc(1, 12'($urandom), 1);
    checks++; if (out_valid !== 1'b1 || out_data !== m_data) begin
      errors++; $display("FAIL bp_third: got %b/%h want 1/%h", out_valid, out_data, m_data);
    end
  endtask

  task automatic test_simultaneous();
    logic [15:0] exp_d;
    cyc(0, 12'h0, 1);
    repeat (N) cyc(1, 12'($urandom), 0);
    exp_d = m_data;
    repeat (N - 1) cyc(1, 12'($urandom), 0);
    cyc(1, 12'($urandom), 1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL simul_valid: got %b want 1", out_valid); end
    checks++; if (out_data !== m_data) begin errors++; $display("FAIL simul_data: got %h want %h (old %h)", out_data, m_data, exp_d); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL simul_ovr: got %b want 0", overrun); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom % 3) != 0, 12'($urandom), ($urandom % 4) == 0);
      checks++;
      if (out_valid !== m_valid || overrun !== m_ovr || (m_valid && out_data !== m_data)) begin
        errors++;
        $display("FAIL rand_%0d: got v=%b d=%h o=%b want v=%b d=%h o=%b",
                 i, out_valid, out_data, overrun, m_valid, m_data, m_ovr);
      end
    end
  endtask

`ifdef ADC_SAMPLE_DECIMATOR_DC_BLOCK_EN
  task automatic test_dc_block();
    logic signed [15:0] prev;
    do_reset();
    prime();
    prev = 16'sh7FFF;
    for (int k = 0; k < 8; k++) begin
      repeat (N) cyc(1, 12'hC00, 1);
      checks++; if (out_data !== m_data) begin errors++; $display("FAIL dc_model_%0d: got %h want %h", k, out_data, m_data); end
      if (k == 0) begin
        checks++; if (out_data !== 16'h4000) begin errors++; $display("FAIL dc_first: got %h want 4000", out_data); end
      end
      if (k == 1) begin
        checks++; if (out_data !== 16'h3FC0) begin errors++; $display("FAIL dc_second: got %h want 3FC0", out_data); end
      end
      checks++; if (!($signed(out_data) < prev)) begin errors++; $display("FAIL dc_decay_%0d: got %h prev %h", k, out_data, prev); end
      prev = $signed(out_data);
    end
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_averaging();
    test_rounding();
    test_backpressure();
    test_simultaneous();
`ifdef ADC_SAMPLE_DECIMATOR_DC_BLOCK_EN
    test_dc_block();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
